// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and width helpers for the PWM controller
// Purpose: default parameter values, PWM period derivation and a clog2 helper
//          (minimum result 1) used by every module of the controller.
package pwm_pkg;

  localparam int DEF_N_CH      = 4;
  localparam int DEF_CW        = 7;
  localparam int DEF_DB_CYCLES = 500000;
  localparam int DEF_STEP      = 1;
  localparam int DEF_PRESC     = 1;

  // Counter counts 0..PERIOD-1, so a duty of PERIOD keeps the output high.
  function automatic int pwm_period(input int cw);
    return (1 << cw) - 1;
  endfunction

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int pwm_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and press pulse
// Purpose: two-flop synchroniser, stability counter and rising-edge pulse.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   btn    in   raw asynchronous button level
//   press  out  one-cycle pulse on each accepted 0->1 transition
module btn_debounce
  import pwm_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int DBW = pwm_clog2(DB_CYCLES + 1);

  logic           sync1;
  logic           sync2;
  logic           level;
  logic [DBW-1:0] stable_cnt;
  logic           differ;
  logic           accept;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any return to agreement restarts it.
  assign differ = (sync2 != level);
  assign accept = differ && (stable_cnt == DBW'(DB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= accept && sync2;
      if (!differ || accept) stable_cnt <= '0;
      else                   stable_cnt <= stable_cnt + DBW'(1);
      if (accept) level <= sync2;
    end
  end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// rtl/pwm_multi_ctrl.sv - multi-channel PWM generator with button duty control
// Purpose: N_CH PWM channels sharing one period counter; three debounced
//          buttons raise/lower the selected channel's duty and step the selection.
// Ports:
//   clk        in   system clock
//   rst_i      in   asynchronous active-low reset
//   btn_up_i   in   raw button, raise duty of selected channel
//   btn_dn_i   in   raw button, lower duty of selected channel
//   btn_sel_i  in   raw button, advance selected channel
//   pwm_o      out  registered PWM outputs, bit k = channel k
//   duty_o     out  active (shadow) duty of the selected channel
//   chan_o     out  selected channel index
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int CW        = DEF_CW,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int STEP      = DEF_STEP,
  parameter int PRESC     = DEF_PRESC
) (
  input  logic                       clk,
  input  logic                       rst_i,
  input  logic                       btn_up_i,
  input  logic                       btn_dn_i,
  input  logic                       btn_sel_i,
  output logic [N_CH-1:0]            pwm_o,
  output logic [CW-1:0]              duty_o,
  output logic [pwm_clog2(N_CH)-1:0] chan_o
);

  localparam int PERIOD = pwm_period(CW);
  localparam int CHW    = pwm_clog2(N_CH);
  localparam int PW     = pwm_clog2(PRESC);

  logic           up_p;
  logic           dn_p;
  logic           sel_p;
  logic [PW-1:0]  presc_cnt;
  logic           tick;
  logic           wrap;
  logic [CW-1:0]  cnt;
  logic [CHW-1:0] chan;
  logic [CW-1:0]  shadow_all [N_CH];

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up  (.clk(clk), .rst_n(rst_i), .btn(btn_up_i),  .press(up_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn  (.clk(clk), .rst_n(rst_i), .btn(btn_dn_i),  .press(dn_p));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sel (.clk(clk), .rst_n(rst_i), .btn(btn_sel_i), .press(sel_p));

  assign tick = (presc_cnt == PW'(PRESC - 1));
  assign wrap = tick && (cnt == CW'(PERIOD - 1));

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      presc_cnt <= '0;
      cnt       <= '0;
      chan      <= '0;
      duty_o    <= '0;
      chan_o    <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PW'(1);
      if (tick) cnt <= wrap ? '0 : cnt + CW'(1);
      // Duty logic below samples the old chan on this same edge.
      if (sel_p) chan <= (chan == CHW'(N_CH - 1)) ? '0 : chan + CHW'(1);
      duty_o <= shadow_all[chan];
      chan_o <= chan;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CW-1:0] duty;
    logic [CW-1:0] shadow;
    logic          pwm_q;
    logic          here;
    logic [CW:0]   inc;

    assign here = (chan == CHW'(k));
    // One extra bit so the saturation test sees the carry.
    assign inc  = {1'b0, duty} + (CW+1)'(STEP);

    always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
        duty   <= '0;
        shadow <= '0;
        pwm_q  <= 1'b0;
      end else begin
        if (here && up_p && !dn_p)
          duty <= (inc > (CW+1)'(PERIOD)) ? CW'(PERIOD) : inc[CW-1:0];
        else if (here && dn_p && !up_p)
          duty <= ({1'b0, duty} < (CW+1)'(STEP)) ? '0 : duty - CW'(STEP);
        // Shadow only changes at the period boundary so an edit never
        // truncates or stretches the pulse already in progress.
        if (wrap) shadow <= duty;
        pwm_q <= (cnt < shadow);
      end
    end

    assign shadow_all[k] = shadow;
    assign pwm_o[k]      = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// tb/tb_pwm_multi_ctrl.sv - self-checking bench for pwm_multi_ctrl
module tb_pwm_multi_ctrl;

  localparam int N_CH   = 4;
  localparam int CW     = 4;
  localparam int DB     = 4;
  localparam int STEP   = 1;
  localparam int PERIOD = 15;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic            btn_up_i = 1'b0;
  logic            btn_dn_i = 1'b0;
  logic            btn_sel_i = 1'b0;
  logic [N_CH-1:0] pwm_o;
  logic [CW-1:0]   duty_o;
  logic [1:0]      chan_o;
  logic [N_CH-1:0] pwm3_o;
  logic [CW-1:0]   duty3_o;
  logic [1:0]      chan3_o;

  int checks = 0;
  int errors = 0;
  int m_duty [N_CH];
  int m_chan = 0;
  int hi_cnt [N_CH];

  always #5 clk = ~clk;

  pwm_multi_ctrl #(.N_CH(N_CH), .CW(CW), .DB_CYCLES(DB), .STEP(STEP), .PRESC(1)) dut (
    .clk(clk), .rst_i(rst_i), .btn_up_i(btn_up_i), .btn_dn_i(btn_dn_i), .btn_sel_i(btn_sel_i),
    .pwm_o(pwm_o), .duty_o(duty_o), .chan_o(chan_o)
  );

  pwm_multi_ctrl #(.N_CH(N_CH), .CW(CW), .DB_CYCLES(DB), .STEP(STEP), .PRESC(3)) dut3 (
    .clk(clk), .rst_i(rst_i), .btn_up_i(btn_up_i), .btn_dn_i(btn_dn_i), .btn_sel_i(btn_sel_i),
    .pwm_o(pwm3_o), .duty_o(duty3_o), .chan_o(chan3_o)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour: saturating duty arithmetic on the selected channel.
  function automatic void model_apply(input bit up, input bit dn, input bit sel);
    if (up && !dn)
      m_duty[m_chan] = (m_duty[m_chan] + STEP > PERIOD) ? PERIOD : m_duty[m_chan] + STEP;
    else if (dn && !up)
      m_duty[m_chan] = (m_duty[m_chan] < STEP) ? 0 : m_duty[m_chan] - STEP;
    if (sel) m_chan = (m_chan + 1) % N_CH;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) m_duty[k] = 0;
    m_chan = 0;
  endfunction

  task automatic press(input bit up, input bit dn, input bit sel);
    @(negedge clk);
    btn_up_i = up; btn_dn_i = dn; btn_sel_i = sel;
    repeat (DB + 4) @(negedge clk);
    btn_up_i = 1'b0; btn_dn_i = 1'b0; btn_sel_i = 1'b0;
    repeat (DB + 4) @(negedge clk);
    model_apply(up, dn, sel);
  endtask

  // A steady PWM waveform is high exactly 'duty' samples in any PERIOD window.
  task automatic measure();
    for (int k = 0; k < N_CH; k++) hi_cnt[k] = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      for (int k = 0; k < N_CH; k++) hi_cnt[k] += int'(pwm_o[k]);
    end
  endtask

  task automatic check_all(input string tag);
    repeat (2 * PERIOD + 2) @(negedge clk);
    check({tag, " duty_o"}, int'(duty_o), m_duty[m_chan]);
    check({tag, " chan_o"}, int'(chan_o), m_chan);
    measure();
    for (int k = 0; k < N_CH; k++)
      check($sformatf("%s pwm%0d_high", tag, k), hi_cnt[k], m_duty[k]);
  endtask

  task automatic wait_rise(input bit slow, output bit found);
    logic prev;
    logic cur;
    found = 1'b0;
    prev = slow ? pwm3_o[0] : pwm_o[0];
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      cur = slow ? pwm3_o[0] : pwm_o[0];
      if (cur && !prev) found = 1'b1;
      prev = cur;
    end
  endtask

  initial begin
    bit   found;
    bit   done;
    logic prev;
    logic cur;
    int   c1, c2, n, hi, op;

    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst pwm_o", int'(pwm_o), 0);
    check("rst duty_o", int'(duty_o), 0);
    check("rst chan_o", int'(chan_o), 0);
    rst_i = 1'b1;
    check_all("idle");

    // Three up presses on ch0
    repeat (3) press(1, 0, 0);
    check_all("up3");

    // Saturate high, then low
    repeat (20) press(1, 0, 0);
    check_all("sat_hi");
    repeat (20) press(0, 1, 0);
    check_all("sat_lo");

    // Glitches shorter than the debounce window are ignored
    for (int g = 1; g < DB; g++) begin
      @(negedge clk); btn_up_i = 1'b1;
      repeat (g) @(negedge clk);
      btn_up_i = 1'b0;
      repeat (DB + 2) @(negedge clk);
    end
    press(1, 0, 0);
    check_all("glitch");
    press(1, 1, 0);
    check_all("up_dn_same");

    // Channel select sequence 1,2,3,0,1
    for (int s = 0; s < 5; s++) begin
      press(0, 0, 1);
      repeat (2) @(negedge clk);
      check($sformatf("sel%0d chan_o", s), int'(chan_o), (s + 1) % N_CH);
    end
    press(0, 0, 1);
    press(1, 0, 1);
    check_all("sel_up");

    // Mid-period edit on ch3: duty 5 -> 6 applied at the next period start
    repeat (5) press(1, 0, 0);
    check_all("ch3_5");
    wait_rise(1'b0, found);
    check("phase_rise_found", int'(found), 1);
    btn_up_i = 1'b1;
    c1 = int'(pwm_o[3]);
    c2 = 0;
    for (int i = 1; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (i == DB + 4) btn_up_i = 1'b0;
      if (i < PERIOD) c1 += int'(pwm_o[3]);
      else            c2 += int'(pwm_o[3]);
    end
    repeat (DB + 4) @(negedge clk);
    model_apply(1, 0, 0);
    check("midperiod_current", c1, 5);
    check("midperiod_next", c2, 6);

    // Prescaled instance: 45-cycle period, ch0 high 3 cycles per duty unit
    repeat (100) @(negedge clk);
    check("presc3 duty_o", int'(duty3_o), m_duty[m_chan]);
    wait_rise(1'b1, found);
    check("presc3_rise_found", int'(found), 1);
    n = 1; hi = 1; prev = 1'b1; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      cur = pwm3_o[0];
      if (cur && !prev) done = 1'b1;
      else begin
        n++;
        hi += int'(cur);
      end
      prev = cur;
    end
    check("presc3_period", n, 3 * PERIOD);
    check("presc3_high", hi, 3 * m_duty[0]);

    // Randomised presses against the model
    for (int r = 0; r < 12; r++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: press(1, 0, 0);
        1: press(0, 1, 0);
        2: press(0, 0, 1);
        3: press(1, 0, 1);
        default: press(0, 1, 1);
      endcase
      check_all($sformatf("rnd%0d", r));
    end

    // Reset mid-period and mid-debounce, up held across release
    press(1, 0, 0);
    check_all("pre_rst");
    @(negedge clk);
    btn_up_i = 1'b1; btn_sel_i = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_i = 1'b0;
    #1;
    check("async_rst pwm_o", int'(pwm_o), 0);
    check("async_rst duty_o", int'(duty_o), 0);
    check("async_rst chan_o", int'(chan_o), 0);
    check("async_rst pwm3_o", int'(pwm3_o), 0);
    model_reset();
    @(negedge clk);
    btn_sel_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b1;
    repeat (4 * (DB + 4)) @(negedge clk);
    btn_up_i = 1'b0;
    repeat (DB + 4) @(negedge clk);
    model_apply(1, 0, 0);
    check_all("held_across_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi_ctrl.md
PWM_MULTI_CTRL -- requirements
Module: pwm_multi_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of independent PWM channels (1..16).
REQ-002 Parameter CW, default 7: duty/counter width; PWM period is PERIOD = 2^CW - 1 ticks.
REQ-003 Parameter DB_CYCLES, default 500000: clock cycles a synchronised button level must hold before it is accepted.
REQ-004 Parameter STEP, default 1: duty increment/decrement per accepted press, 1..PERIOD.
REQ-005 Parameter PRESC, default 1: clock cycles per PWM tick, >= 1.
REQ-006 clk  input  1  single system clock; all state on rising edge.
REQ-007 rst_i  input  1  reset, asynchronous assert, active-low.
REQ-008 btn_up_i  input  1  raw, asynchronous button: raise duty of selected channel.
REQ-009 btn_dn_i  input  1  raw, asynchronous button: lower duty of selected channel.
REQ-010 btn_sel_i  input  1  raw, asynchronous button: advance selected channel.
REQ-011 pwm_o  output  N_CH  registered PWM outputs, bit k = channel k.
REQ-012 duty_o  output  CW  active duty of selected channel, for seven-segment display.
REQ-013 chan_o  output  clog2(N_CH), min 1  index of selected channel.

Function
REQ-014 Each button SHALL pass a 2-flop synchroniser, then a stability counter; the debounced level changes only after DB_CYCLES consecutive cycles of a new synchronised level.
REQ-015 A one-cycle press pulse SHALL fire on each debounced 0->1 transition only; holding gives no repeat; release gives no pulse.
REQ-016 Up pulse: duty[chan] <= min(duty[chan] + STEP, PERIOD), computed at CW+1 bits, no wrap.
REQ-017 Down pulse: duty[chan] <= max(duty[chan] - STEP, 0), no underflow wrap.
REQ-018 Up and down pulses in the same cycle SHALL leave duty unchanged.
REQ-019 A select pulse SHALL advance chan: N_CH-1 wraps to 0.
REQ-020 Select pulse with an up/down pulse in the same cycle: the duty change applies to the old channel, and chan advances on the same edge.
REQ-021 A prescaler SHALL emit a tick every PRESC cycles; the period counter counts 0..PERIOD-1 on ticks, then wraps to 0.
REQ-022 Each channel SHALL have a shadow duty, loaded from duty[k] only on the tick where the counter wraps to 0; mid-period edits never glitch the output.
REQ-023 pwm_o[k] SHALL be registered as (counter < shadow[k]); duty 0 gives constant low, duty PERIOD gives constant high.
REQ-024 duty_o SHALL show the shadow (active) duty of chan; chan_o SHALL show chan; both are registered.
REQ-025 Latency: raw edge to pulse is 2 + DB_CYCLES cycles (+-1); pulse to duty register is 1 cycle; the output reflects the new duty from the next period start.

Reset
REQ-026 While rst_i = 0: all duty and shadow registers = 0; chan = 0; prescaler and period counter = 0; debounced levels = 0; pwm_o, duty_o, chan_o = 0.
REQ-027 After rst_i deasserts, a button already held SHALL produce one pulse after debounce, then none until released.
REQ-028 Reset mid-period or mid-debounce SHALL abandon all progress, with no partial update retained.

Structure
REQ-029 A shared package pwm_pkg SHALL hold the PERIOD derivation function, clog2 helper and default parameter constants.
REQ-030 A sub-module btn_debounce (synchroniser, stability counter, edge pulse, DB_CYCLES parameter) SHALL be instantiated three times.
REQ-031 Channel duty/shadow/compare logic SHALL use a generate loop over N_CH; no per-channel hand copies.

Verification (N_CH=4, CW=4 -> PERIOD=15, DB_CYCLES=4, STEP=1, PRESC=1 unless stated)
REQ-032 Reset, then 3 up presses on ch0 -> duty_o=3 after the next wrap; pwm_o[0] high 3 of 15 ticks; other channels low.
REQ-033 20 up presses -> duty saturates at 15 with pwm_o[0] constant high; 20 down presses -> 0, constant low, no wrap.
REQ-034 Glitchy up input (pulses shorter than 4 cycles), then 1 stable press -> exactly one increment; up and down in the same cycle -> no change.
REQ-035 5 select presses -> chan_o sequence 1,2,3,0,1; select and up in the same cycle on chan 2 -> ch2 duty +1, chan_o=3.
REQ-036 Up press at counter=7 with duty 5 -> current period keeps 5 high ticks; the next period shows 6; with PRESC=3, period = 45 clk cycles.
REQ-037 rst_i asserted mid-period with duties nonzero -> all outputs 0 asynchronously; held button across reset release -> single pulse.
